// File: rtl/snoop_bus_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : snoop_bus_arbiter
// Description : Round-robin arbiter and transaction sequencer for a MESI
//               snooping bus. ARB_TIMEOUT_EN adds a memory-wait timeout on err.
// Revision    : 1.0
// =============================================================================
module snoop_bus_arbiter #(
    parameter int NUM_CACHES = 4,
    parameter int ADDR_W     = 32,
    parameter int SNOOP_LAT  = 2
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic [NUM_CACHES-1:0]         req,
    input  logic [2*NUM_CACHES-1:0]       req_op,
    input  logic [ADDR_W*NUM_CACHES-1:0]  req_addr,
    output logic [NUM_CACHES-1:0]         gnt,
    output logic [NUM_CACHES-1:0]         done,
    output logic                          shared_out,
    output logic                          bus_valid,
    output logic [1:0]                    bus_op,
    output logic [ADDR_W-1:0]             bus_addr,
    output logic [$clog2(NUM_CACHES)-1:0] bus_src,
    input  logic [NUM_CACHES-1:0]         snoop_hit,
    input  logic [NUM_CACHES-1:0]         snoop_flush,
    output logic                          mem_wb_req,
    output logic                          mem_rd_req,
    input  logic                          mem_ack,
    output logic                          err
);
    localparam int         IDX_W      = $clog2(NUM_CACHES);
    localparam logic [1:0] OP_BUSRD   = 2'b01;
    localparam logic [1:0] OP_BUSUPGR = 2'b11;
    localparam logic [2:0] LAST_SNOOP = 3'(SNOOP_LAT - 1);

    typedef enum logic [2:0] {IDLE, GRANT, BCAST, SNOOP, FLUSH, MEM, DONE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic              hit_q;
    logic              flush_q;
    logic [2:0]        snoop_cnt;

    logic              arb_found;
    logic [IDX_W-1:0]  arb_idx;
    logic [IDX_W-1:0]  cand;
    logic [1:0]        arb_op;
    logic [ADDR_W-1:0] arb_addr;
    logic [NUM_CACHES-1:0] others;
    logic              hit_now;
    logic              flush_now;

    // Search starts just after the last served cache so every requester is reached within N grants.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_CACHES; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_CACHES);
            if (!arb_found && req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        arb_op   = OP_BUSRD;
        arb_addr = '0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                arb_op   = req_op[2*i +: 2];
                arb_addr = req_addr[ADDR_W*i +: ADDR_W];
            end
        end
        if (arb_op == 2'b00) arb_op = OP_BUSRD;
        // The requester's own snoop lines say nothing about other copies.
        others      = '1;
        others[idx] = 1'b0;
        hit_now     = hit_q | (|(snoop_hit & others));
        flush_now   = flush_q | (|(snoop_flush & others));
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       tmo_hit;
    assign tmo_hit = (tmo_cnt == 8'd254);
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= IDLE;
            rr_ptr     <= IDX_W'(NUM_CACHES - 1);
            idx        <= '0;
            op         <= '0;
            addr       <= '0;
            hit_q      <= 1'b0;
            flush_q    <= 1'b0;
            snoop_cnt  <= '0;
            gnt        <= '0;
            done       <= '0;
            shared_out <= 1'b0;
            bus_valid  <= 1'b0;
            bus_op     <= '0;
            bus_addr   <= '0;
            bus_src    <= '0;
            mem_wb_req <= 1'b0;
            mem_rd_req <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
            err        <= 1'b0;
`endif
        end else begin
            bus_valid  <= 1'b0;
            done       <= '0;
            shared_out <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            err        <= 1'b0;
            tmo_cnt    <= '0;
`endif
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        idx   <= arb_idx;
                        op    <= arb_op;
                        addr  <= arb_addr;
                        gnt   <= NUM_CACHES'(1) << arb_idx;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    bus_valid <= 1'b1;
                    bus_op    <= op;
                    bus_addr  <= addr;
                    bus_src   <= idx;
                    hit_q     <= 1'b0;
                    flush_q   <= 1'b0;
                    snoop_cnt <= '0;
                    state     <= BCAST;
                end
                BCAST: state <= SNOOP;
                SNOOP: begin
                    hit_q     <= hit_now;
                    flush_q   <= flush_now;
                    snoop_cnt <= snoop_cnt + 3'd1;
                    if (snoop_cnt == LAST_SNOOP) begin
                        if (flush_now) begin
                            mem_wb_req <= 1'b1;
                            state      <= FLUSH;
                        end else if (op == OP_BUSUPGR) begin
                            done       <= gnt;
                            shared_out <= hit_now;
                            state      <= DONE;
                        end else begin
                            mem_rd_req <= 1'b1;
                            state      <= MEM;
                        end
                    end
                end
                FLUSH: begin
                    if (mem_ack) begin
                        mem_wb_req <= 1'b0;
                        if (op == OP_BUSUPGR) begin
                            done       <= gnt;
                            shared_out <= hit_q;
                            state      <= DONE;
                        end else begin
                            mem_rd_req <= 1'b1;
                            state      <= MEM;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        mem_wb_req <= 1'b0;
                        done       <= gnt;
                        err        <= 1'b1;
                        state      <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end
                MEM: begin
                    if (mem_ack) begin
                        mem_rd_req <= 1'b0;
                        done       <= gnt;
                        shared_out <= hit_q;
                        state      <= DONE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        mem_rd_req <= 1'b0;
                        done       <= gnt;
                        err        <= 1'b1;
                        state      <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end
                DONE: begin
                    gnt      <= '0;
                    rr_ptr   <= idx;
                    bus_op   <= '0;
                    bus_addr <= '0;
                    bus_src  <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_snoop_bus_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : tb_snoop_bus_arbiter
// Description : Randomized self-checking bench for snoop_bus_arbiter.
// Revision    : 1.0
// =============================================================================
module tb_snoop_bus_arbiter;
    localparam int N  = 4;
    localparam int L  = 2;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rstb;
    logic [N-1:0]  req;
    logic [2*N-1:0] req_op;
    logic [AW*N-1:0] req_addr;
    logic [N-1:0]  gnt, done;
    logic          shared_out, bus_valid;
    logic [1:0]    bus_op;
    logic [AW-1:0] bus_addr;
    logic [1:0]    bus_src;
    logic [N-1:0]  snoop_hit, snoop_flush;
    logic          mem_wb_req, mem_rd_req, mem_ack, err;

    always #5 clk = ~clk;

    snoop_bus_arbiter #(.NUM_CACHES(N), .ADDR_W(AW), .SNOOP_LAT(L)) dut (
        .clk(clk), .rstb(rstb), .req(req), .req_op(req_op), .req_addr(req_addr),
        .gnt(gnt), .done(done), .shared_out(shared_out), .bus_valid(bus_valid),
        .bus_op(bus_op), .bus_addr(bus_addr), .bus_src(bus_src),
        .snoop_hit(snoop_hit), .snoop_flush(snoop_flush),
        .mem_wb_req(mem_wb_req), .mem_rd_req(mem_rd_req), .mem_ack(mem_ack), .err(err)
    );

    int checks = 0;
    int passes = 0;
    int last_served = N - 1;

    logic [N-1:0]  ob_gnt, ob_done, ob_done_after, ob_gnt_after;
    logic [1:0]    ob_op, ob_src;
    logic [AW-1:0] ob_addr;
    logic          ob_bv_after, ob_wb, ob_rd, ob_both, ob_shared, ob_err, ob_to;
    int            ob_wb_first, ob_rd_first, ob_cyc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Plays the snooping caches and memory for one transaction and records what the arbiter did.
    task automatic drive_txn(input logic [N-1:0] hit_pat, input logic [N-1:0] flush_pat,
                             input int wb_dly, input int rd_dly);
        int t, wb_n, rd_n;
        ob_wb = 0; ob_rd = 0; ob_both = 0; ob_to = 1;
        ob_wb_first = -1; ob_rd_first = -1; ob_cyc = 0;
        t = 0;
        while (gnt == '0 && t < 20) begin step(); ob_cyc++; t++; end
        ob_gnt = gnt;
        t = 0;
        while (!bus_valid && t < 20) begin step(); ob_cyc++; t++; end
        ob_op = bus_op; ob_addr = bus_addr; ob_src = bus_src;
        step(); ob_cyc++;
        ob_bv_after = bus_valid;
        snoop_hit = hit_pat; snoop_flush = flush_pat;
        repeat (L) begin step(); ob_cyc++; end
        snoop_hit = '0; snoop_flush = '0;
        wb_n = 0; rd_n = 0; t = 0;
        while (t < 400) begin
            mem_ack = 1'b0;
            if (done != '0) begin ob_to = 0; break; end
            if (mem_wb_req && mem_rd_req) ob_both = 1;
            if (mem_wb_req) begin
                ob_wb = 1;
                if (ob_wb_first < 0) ob_wb_first = ob_cyc;
                if (wb_n == wb_dly) mem_ack = 1'b1;
                wb_n++;
            end else if (mem_rd_req) begin
                ob_rd = 1;
                if (ob_rd_first < 0) ob_rd_first = ob_cyc;
                if (rd_n == rd_dly) mem_ack = 1'b1;
                rd_n++;
            end
            step(); ob_cyc++; t++;
        end
        mem_ack = 1'b0;
        ob_done = done; ob_shared = shared_out; ob_err = err;
        step();
        ob_done_after = done; ob_gnt_after = gnt;
    endtask

    task automatic set_cache(input int c, input logic [1:0] op, input logic [AW-1:0] a);
        req_op[2*c +: 2]    = op;
        req_addr[AW*c +: AW] = a;
    endtask

    task automatic test_reset();
        rstb = 1'b0; req = '0; req_op = '0; req_addr = '0;
        snoop_hit = '0; snoop_flush = '0; mem_ack = 1'b0;
        repeat (3) step();
        checks++; if (gnt !== 4'b0) $display("FAIL reset_gnt: got %b want 0000", gnt); else passes++;
        checks++; if ({done, shared_out, err} !== 6'b0) $display("FAIL reset_done: got %b want 0", {done, shared_out, err}); else passes++;
        checks++; if ({bus_valid, bus_op, bus_addr, bus_src} !== 37'b0) $display("FAIL reset_bus: got %h want 0", {bus_valid, bus_op, bus_addr, bus_src}); else passes++;
        rstb = 1'b1;
        step();
        checks++; if ({mem_wb_req, mem_rd_req, gnt} !== 6'b0) $display("FAIL reset_idle: got %b want 0", {mem_wb_req, mem_rd_req, gnt}); else passes++;
        last_served = N - 1;
    endtask

    task automatic test_single_read();
        set_cache(1, 2'b01, 32'h40);
        req = 4'b0010;
        drive_txn('0, '0, 0, 2);
        req = '0;
        checks++; if (ob_gnt !== 4'b0010) $display("FAIL single_gnt: got %b want 0010", ob_gnt); else passes++;
        checks++; if ({ob_op, ob_src, ob_addr} !== {2'b01, 2'd1, 32'h40}) $display("FAIL single_bus: got %h want %h", {ob_op, ob_src, ob_addr}, {2'b01, 2'd1, 32'h40}); else passes++;
        checks++; if (ob_bv_after !== 1'b0) $display("FAIL single_bv_pulse: got %b want 0", ob_bv_after); else passes++;
        checks++; if ({ob_wb, ob_rd} !== 2'b01) $display("FAIL single_mem: got %b want 01", {ob_wb, ob_rd}); else passes++;
        checks++; if ({ob_done, ob_shared, ob_err} !== {4'b0010, 2'b00}) $display("FAIL single_done: got %b want 001000", {ob_done, ob_shared, ob_err}); else passes++;
        checks++; if ({ob_done_after, ob_gnt_after} !== 8'b0) $display("FAIL single_release: got %b want 0", {ob_done_after, ob_gnt_after}); else passes++;
        last_served = 1;
    endtask

    task automatic test_shared_read();
        set_cache(0, 2'b01, 32'h1000);
        req = 4'b0001;
        drive_txn(4'b0100, '0, 1, 1);
        checks++; if ({ob_done, ob_shared} !== 5'b00011) $display("FAIL shared_hit: got %b want 00011", {ob_done, ob_shared}); else passes++;
        drive_txn(4'b0001, '0, 1, 1);
        req = '0;
        checks++; if ({ob_done, ob_shared} !== 5'b00010) $display("FAIL shared_own_masked: got %b want 00010", {ob_done, ob_shared}); else passes++;
        last_served = 0;
    endtask

    task automatic test_dirty_hit();
        set_cache(3, 2'b10, 32'hABC0);
        req = 4'b1000;
        drive_txn(4'b0010, 4'b0010, 2, 1);
        req = '0;
        checks++; if ({ob_wb, ob_rd, ob_both} !== 3'b110) $display("FAIL dirty_mem: got %b want 110", {ob_wb, ob_rd, ob_both}); else passes++;
        checks++; if (!(ob_rd_first > ob_wb_first)) $display("FAIL dirty_order: got rd@%0d wb@%0d want rd after wb", ob_rd_first, ob_wb_first); else passes++;
        checks++; if ({ob_done, ob_shared, ob_err} !== 6'b100010) $display("FAIL dirty_done: got %b want 100010", {ob_done, ob_shared, ob_err}); else passes++;
        last_served = 3;
    endtask

    task automatic test_upgrade();
        step();
        set_cache(2, 2'b11, 32'h77);
        req = 4'b0100;
        drive_txn('0, '0, 0, 0);
        req = '0;
        checks++; if (ob_cyc !== 3 + L) $display("FAIL upgr_latency: got %0d want %0d", ob_cyc, 3 + L); else passes++;
        checks++; if ({ob_wb, ob_rd} !== 2'b00) $display("FAIL upgr_nomem: got %b want 00", {ob_wb, ob_rd}); else passes++;
        checks++; if ({ob_done, ob_op} !== 6'b010011) $display("FAIL upgr_done: got %b want 010011", {ob_done, ob_op}); else passes++;
        last_served = 2;
    endtask

    task automatic test_random();
        logic [N-1:0]  pend, hp, fp, wmask;
        logic [1:0]    ops [N];
        logic [AW-1:0] addrs [N];
        logic [1:0]    eop;
        int w;
        pend = '0;
        for (int it = 0; it < 24; it++) begin
            for (int c = 0; c < N; c++) begin
                if (!pend[c] && ($urandom_range(0, 1) == 1)) begin
                    pend[c]  = 1'b1;
                    ops[c]   = 2'($urandom_range(0, 3));
                    addrs[c] = $urandom;
                    set_cache(c, ops[c], addrs[c]);
                end
            end
            if (pend == '0) begin
                pend[0] = 1'b1; ops[0] = 2'b10; addrs[0] = $urandom;
                set_cache(0, ops[0], addrs[0]);
            end
            req = pend;
            w = -1;
            for (int k = 1; k <= N; k++)
                if (w < 0 && pend[(last_served + k) % N]) w = (last_served + k) % N;
            wmask = 4'b0001 << w;
            eop = (ops[w] == 2'b00) ? 2'b01 : ops[w];
            hp = 4'($urandom);
            fp = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            drive_txn(hp, fp, $urandom_range(0, 3), $urandom_range(0, 3));
            checks++; if (ob_gnt !== wmask) $display("FAIL rand_gnt[%0d]: got %b want %b", it, ob_gnt, wmask); else passes++;
            checks++; if ({ob_op, ob_src, ob_addr} !== {eop, 2'(w), addrs[w]}) $display("FAIL rand_bus[%0d]: got %h want %h", it, {ob_op, ob_src, ob_addr}, {eop, 2'(w), addrs[w]}); else passes++;
            checks++; if (ob_wb !== |(fp & ~wmask)) $display("FAIL rand_wb[%0d]: got %b want %b", it, ob_wb, |(fp & ~wmask)); else passes++;
            checks++; if (ob_rd !== (eop != 2'b11)) $display("FAIL rand_rd[%0d]: got %b want %b", it, ob_rd, eop != 2'b11); else passes++;
            checks++; if ({ob_done, ob_shared, ob_err} !== {wmask, |(hp & ~wmask), 1'b0}) $display("FAIL rand_done[%0d]: got %b want %b", it, {ob_done, ob_shared, ob_err}, {wmask, |(hp & ~wmask), 1'b0}); else passes++;
            pend[w] = 1'b0;
            req = pend;
            last_served = w;
        end
        req = '0;
        step();
    endtask

    task automatic test_fairness();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int t;
        rstb = 1'b0;
        for (int c = 0; c < N; c++) set_cache(c, 2'b01, AW'(32'h100 * (c + 1)));
        req = 4'b1111;
        step();
        rstb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_txn('0, '0, 0, 0);
            checks++; if (ob_gnt !== (4'b0001 << exp_order[i])) $display("FAIL fair_gnt[%0d]: got %b want %b", i, ob_gnt, 4'b0001 << exp_order[i]); else passes++;
        end
        t = 0;
        while (!mem_rd_req && t < 20) begin step(); t++; end
        checks++; if (mem_rd_req !== 1'b1) $display("FAIL abort_reach_mem: got %b want 1", mem_rd_req); else passes++;
        #2 rstb = 1'b0;
        #1;
        checks++; if ({gnt, done, shared_out, err, mem_wb_req, mem_rd_req} !== 12'b0) $display("FAIL abort_ctl: got %b want 0", {gnt, done, shared_out, err, mem_wb_req, mem_rd_req}); else passes++;
        checks++; if ({bus_valid, bus_op, bus_addr, bus_src} !== 37'b0) $display("FAIL abort_bus: got %h want 0", {bus_valid, bus_op, bus_addr, bus_src}); else passes++;
        req = '0;
        step();
        rstb = 1'b1;
        last_served = N - 1;
    endtask

    task automatic test_mem_timeout();
        set_cache(1, 2'b01, 32'h5550);
        req = 4'b0010;
        drive_txn('0, '0, 0, 100000);
        req = '0;
`ifdef ARB_TIMEOUT_EN
        checks++; if (ob_to !== 1'b0) $display("FAIL tmo_done_seen: got %b want 0", ob_to); else passes++;
        checks++; if ({ob_done, ob_err, ob_shared} !== 6'b001010) $display("FAIL tmo_done: got %b want 001010", {ob_done, ob_err, ob_shared}); else passes++;
        checks++; if (mem_rd_req !== 1'b0) $display("FAIL tmo_rd_drop: got %b want 0", mem_rd_req); else passes++;
`else
        checks++; if ({ob_to, ob_done} !== 5'b10000) $display("FAIL hang_no_done: got %b want 10000", {ob_to, ob_done}); else passes++;
        checks++; if ({mem_rd_req, err} !== 2'b10) $display("FAIL hang_in_mem: got %b want 10", {mem_rd_req, err}); else passes++;
`endif
        step();
        rstb = 1'b0;
        step();
        rstb = 1'b1;
        last_served = N - 1;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_shared_read();
        test_dirty_hit();
        test_upgrade();
        test_random();
        test_fairness();
        test_mem_timeout();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
`default_nettype wire
